// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 8-digit display with a guaranteed minimum dwell per grant.
// The owner's word is forwarded (registered) on encoded while it keeps requesting.
module display_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter int          DWELL        = 50_000_000,
    parameter logic [31:0] IDLE_PATTERN = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      ack,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    busy,
    output logic [31:0]             encoded
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DWELL);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t          state_reg;
    // The current owner is always the last winner, so one pointer serves both roles.
    logic [IW-1:0]   last_reg;
    logic [CW-1:0]   count_reg;

    logic [31:0]     data_word [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_word[gi] = req_data[32*gi +: 32];
        end
    endgenerate

    logic                found;
    logic [IW-1:0]       winner;
    logic [IW-1:0]       idx;
    logic [NUM_REQ-1:0]  win_onehot;

    // Scan last+1, last+2, ... wrapping, ending at last itself; first asserted bit wins.
    always_comb begin
        found      = 1'b0;
        winner     = '0;
        idx        = '0;
        win_onehot = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_reg) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        win_onehot[winner] = 1'b1;
    end

    wire dwell_done = (count_reg == CW'(DWELL - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            last_reg  <= IW'(NUM_REQ - 1);
            count_reg <= '0;
            encoded   <= IDLE_PATTERN;
            grant     <= '0;
            ack       <= '0;
            busy      <= 1'b0;
        end else begin
            ack <= '0;
            if (state_reg == IDLE || dwell_done) begin
                if (found) begin
                    state_reg <= SHOW;
                    last_reg  <= winner;
                    count_reg <= '0;
                    encoded   <= data_word[winner];
                    grant     <= win_onehot;
                    ack       <= win_onehot;
                    busy      <= 1'b1;
                end else begin
                    // Nobody wants the display: release it but leave the last word showing.
                    state_reg <= IDLE;
                    count_reg <= '0;
                    grant     <= '0;
                    busy      <= 1'b0;
                end
            end else begin
                count_reg <= count_reg + CW'(1);
                if (req[last_reg])
                    encoded <= data_word[last_reg];
            end
        end
    end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 8-digit seven-segment display between `NUM_REQ` requesters. Runs a round-robin arbiter with a minimum dwell time, so each granted source stays on the display long enough to be read. Drives the 32-bit `encoded` nibble word (digit 0 = bits [3:0]) consumed by the display driver. Sits between the system status sources and the `seven_segment` block.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `DWELL`, 50_000_000: clock cycles a grant is held before re-arbitration; must be ≥ 2.
- `IDLE_PATTERN`, 32'h0000_0000: value driven on `encoded` out of reset.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, `NUM_REQ`: per-requester display request, level-sensitive.
- `req_data`, input, `NUM_REQ*32`: requester i's word at bits [32*i+31 : 32*i].
- `ack`, output, `NUM_REQ`: one-cycle pulse to requester i when its grant starts.
- `grant`, output, `NUM_REQ`: one-hot current owner; all zero when idle.
- `busy`, output, 1: high while in SHOW.
- `encoded`, output, 32: word forwarded to the display driver.

## Operation
- States: IDLE and SHOW. Internal state: `owner` index, `last` pointer, and a dwell counter of width `$clog2(DWELL)`.
- IDLE:
  - If any `req` bit is high, pick the winner by scanning indices `last+1`, `last+2`, … modulo `NUM_REQ`, ending with `last` itself. The first asserted bit wins.
  - On a win: latch `encoded <= req_data[winner]`, set `grant` one-hot, pulse `ack[winner]`, set `owner = last = winner`, clear the dwell counter, go to SHOW.
  - If no `req` bit is high, hold `encoded` and keep `grant` at 0.
- SHOW:
  - Dwell counter increments every cycle.
  - While `req[owner]` is 1, `encoded` follows `req_data[owner]` each cycle (live update, registered).
  - If `req[owner]` drops, `encoded` holds its last value and the dwell period still runs to completion. Minimum dwell is guaranteed.
  - Changes on other requesters' `req` bits do not affect the current grant until the dwell expires.
- Dwell expiry (counter == `DWELL-1`):
  - Re-arbitrate with the same scan order, starting at `owner+1`.
  - If a winner is found (including the current owner, which wins only when no one else is requesting): new grant, `ack` pulse, counter cleared, stay in SHOW.
  - If no winner: go to IDLE. `grant` = 0 and `busy` = 0. `encoded` keeps the last displayed value; no blanking.
- `ack` asserts only on the cycle a grant begins, including a re-grant to the same owner.
- `grant`, `busy` and `encoded` are always registered outputs.
- Reset (asynchronous, any time, including mid-dwell):
  - `encoded` = `IDLE_PATTERN`, `grant` = 0, `ack` = 0, `busy` = 0.
  - State = IDLE, `last` = `NUM_REQ-1` (so index 0 is scanned first), counter = 0.
  - After reset deasserts, the first arbitration happens on the next rising edge.

## Timing
- IDLE→SHOW latency: `req` sampled high at edge N gives `grant`, `ack`, `busy` and the new `encoded` valid after edge N (visible in cycle N+1).
- Live data update latency: 1 cycle from `req_data` to `encoded`.
- A grant lasts exactly `DWELL` cycles: `grant` is stable from cycle N+1 through N+`DWELL`, and the next grant or IDLE takes effect at cycle N+`DWELL`+1.
- With continuous requests there is no gap cycle between consecutive grants; `busy` stays high.
- `ack` width is exactly 1 cycle.
- At most one `grant` bit and at most one `ack` bit are ever high.

## Test plan
Parameters for all scenarios: `NUM_REQ`=4, `DWELL`=8.

1. **Reset:** assert `reset` mid-SHOW.
   - Immediately `encoded`=32'h0, `grant`=0, `busy`=0, without waiting for a clock edge.
   - After release with `req`=4'b0001 and data 32'h1234_5678: `grant`=4'b0001, `ack`=4'b0001 for 1 cycle, `encoded`=32'h1234_5678 one cycle later.
2. **Round-robin:** `req`=4'b1111 held, data words 32'hAAAA_0000+i.
   - Grant order is 0,1,2,3,0, each lasting exactly 8 cycles.
   - One `ack` pulse per grant; `busy` is never low.
3. **Sole requester re-grant:** only `req[2]` high for 20 cycles.
   - `grant`=4'b0100 continuously.
   - `ack[2]` pulses at cycles 1, 9 and 17.
4. **Live update and drop:**
   - Owner 1 changes data to 32'hDEAD_BEEF mid-dwell: `encoded` follows 1 cycle later.
   - `req[1]` then drops at dwell cycle 3: `encoded` holds 32'hDEAD_BEEF, the grant persists to cycle 8, then the block goes IDLE with `grant`=0 and `encoded` still 32'hDEAD_BEEF.
5. **Late requester:** `req[3]` rises at dwell cycle 2 of owner 0's grant.
   - No preemption.
   - `grant`=4'b1000 exactly at cycle 9, with `ack[3]` pulsed at cycle 9.
6. **Simultaneous start:** from IDLE with `last`=1, `req`=4'b1001 arrives in one cycle.
   - Requester 3 wins first (scan order 2, 3, 0, 1), then requester 0.
